// File: rtl/smalldiv_pkg.sv
// Shared sizing helpers and LUT content functions for the small constant divider.
package smalldiv_pkg;

  function automatic int unsigned calc_rw(input int unsigned divider);
    return $clog2(divider);
  endfunction

  function automatic int unsigned calc_cw(input int unsigned lut_width,
                                          input int unsigned divider);
    return lut_width - calc_rw(divider);
  endfunction

  function automatic int unsigned calc_ns(input int unsigned width,
                                          input int unsigned cw);
    return (width + cw - 1) / cw;
  endfunction

  function automatic int unsigned lut_q(input int unsigned value,
                                        input int unsigned divider);
    return value / divider;
  endfunction

  function automatic int unsigned lut_r(input int unsigned value,
                                        input int unsigned divider);
    return value % divider;
  endfunction

endpackage

// File: rtl/smalldiv_stage.sv
// One long-division step: {rem_in, chunk} looked up in constant quotient/remainder tables.
module smalldiv_stage
  import smalldiv_pkg::*;
#(
  parameter int unsigned DIVIDER_VALUE = 5,
  parameter int unsigned RW            = 3,
  parameter int unsigned CW            = 3
) (
  input  logic [RW-1:0] rem_in,
  input  logic [CW-1:0] chunk,
  output logic [CW-1:0] qchunk,
  output logic [RW-1:0] rem_out
);

  localparam int unsigned AW    = RW + CW;
  localparam int unsigned DEPTH = 2 ** AW;

  logic [CW-1:0] q_rom [DEPTH];
  logic [RW-1:0] r_rom [DEPTH];
  logic [AW-1:0] addr;

  // Entries with rem_in >= DIVIDER_VALUE are unreachable; their truncation is harmless.
  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    assign q_rom[a] = CW'(lut_q(a, DIVIDER_VALUE));
    assign r_rom[a] = RW'(lut_r(a, DIVIDER_VALUE));
  end

  assign addr    = {rem_in, chunk};
  assign qchunk  = q_rom[addr];
  assign rem_out = r_rom[addr];

endmodule

// File: rtl/smalldiv.sv
// Unsigned divide by a constant via chunked MSB-first LUT long division, optional in/out registers.
// Optional valid_in/valid_out tracking enabled by defining SMALLDIV_VALID_EN.
module smalldiv
  import smalldiv_pkg::*;
#(
  parameter int unsigned DIVIDER_VALUE         = 5,
  parameter int unsigned DIVIDEND_WIDTH        = 18,
  parameter int unsigned THEORETICAL_LUT_WIDTH = 6,
  parameter int unsigned REGISTER_IN           = 1,
  parameter int unsigned REGISTER_OUT          = 1,
  localparam int unsigned RW = calc_rw(DIVIDER_VALUE)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
`ifdef SMALLDIV_VALID_EN
  input  logic                      valid_in,
  output logic                      valid_out,
`endif
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [RW-1:0]             remainder
);

  localparam int unsigned CW = calc_cw(THEORETICAL_LUT_WIDTH, DIVIDER_VALUE);
  localparam int unsigned NS = calc_ns(DIVIDEND_WIDTH, CW);
  localparam int unsigned PW = NS * CW;

  logic [DIVIDEND_WIDTH-1:0] core_in;
  logic [DIVIDEND_WIDTH-1:0] core_q;
  logic [RW-1:0]             core_r;
`ifdef SMALLDIV_VALID_EN
  logic                      core_v;
`endif

  // Input register stage
  if (REGISTER_IN != 0) begin : g_in_reg
    logic [DIVIDEND_WIDTH-1:0] dividend_d, dividend_q;
`ifdef SMALLDIV_VALID_EN
    logic valid_d, valid_q;
`endif
    always_comb begin
      dividend_d = dividend_q;
`ifdef SMALLDIV_VALID_EN
      valid_d    = valid_q;
`endif
      if (enable) begin
        dividend_d = dividend;
`ifdef SMALLDIV_VALID_EN
        valid_d    = valid_in;
`endif
      end
    end
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        dividend_q <= '0;
`ifdef SMALLDIV_VALID_EN
        valid_q    <= 1'b0;
`endif
      end else begin
        dividend_q <= dividend_d;
`ifdef SMALLDIV_VALID_EN
        valid_q    <= valid_d;
`endif
      end
    end
    assign core_in = dividend_q;
`ifdef SMALLDIV_VALID_EN
    assign core_v  = valid_q;
`endif
  end else begin : g_in_wire
    assign core_in = dividend;
`ifdef SMALLDIV_VALID_EN
    assign core_v  = valid_in;
`endif
  end

  // Combinational division chain, most significant chunk first
  logic [PW-1:0] padded;
  logic [PW-1:0] q_full;
  logic [RW-1:0] rem_chain [NS+1];

  assign padded       = PW'(core_in);
  assign rem_chain[0] = '0;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    smalldiv_stage #(
      .DIVIDER_VALUE (DIVIDER_VALUE),
      .RW            (RW),
      .CW            (CW)
    ) u_stage (
      .rem_in  (rem_chain[k]),
      .chunk   (padded[(NS-1-k)*CW +: CW]),
      .qchunk  (q_full[(NS-1-k)*CW +: CW]),
      .rem_out (rem_chain[k+1])
    );
  end

  assign core_q = q_full[DIVIDEND_WIDTH-1:0];
  assign core_r = rem_chain[NS];

  // Quotient bits above the dividend width are always zero
  if (PW > DIVIDEND_WIDTH) begin : g_qpad
    logic unused_qpad;
    assign unused_qpad = ^q_full[PW-1:DIVIDEND_WIDTH];
  end

  // Output register stage
  if (REGISTER_OUT != 0) begin : g_out_reg
    logic [DIVIDEND_WIDTH-1:0] quotient_d, quotient_q;
    logic [RW-1:0]             remainder_d, remainder_q;
`ifdef SMALLDIV_VALID_EN
    logic valid_d, valid_q;
`endif
    always_comb begin
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
`ifdef SMALLDIV_VALID_EN
      valid_d     = valid_q;
`endif
      if (enable) begin
        quotient_d  = core_q;
        remainder_d = core_r;
`ifdef SMALLDIV_VALID_EN
        valid_d     = core_v;
`endif
      end
    end
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        quotient_q  <= '0;
        remainder_q <= '0;
`ifdef SMALLDIV_VALID_EN
        valid_q     <= 1'b0;
`endif
      end else begin
        quotient_q  <= quotient_d;
        remainder_q <= remainder_d;
`ifdef SMALLDIV_VALID_EN
        valid_q     <= valid_d;
`endif
      end
    end
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef SMALLDIV_VALID_EN
    assign valid_out = valid_q;
`endif
  end else begin : g_out_wire
    assign quotient  = core_q;
    assign remainder = core_r;
`ifdef SMALLDIV_VALID_EN
    assign valid_out = core_v;
`endif
  end

  // Purely combinational build leaves the clocking inputs idle
  if (REGISTER_IN == 0 && REGISTER_OUT == 0) begin : g_no_reg
    logic unused_ctrl;
    assign unused_ctrl = ^{clock, reset, enable};
  end

endmodule

// File: tb/tb_smalldiv.sv
// Self-checking bench: four smalldiv configurations (latency 2/1/1/0) driven by one shared stream.
module tb_smalldiv;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        v;
  } exp_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] q3, r3, q5, r5, q7, r7, q11, r11;
  } vec_t;

  localparam exp_t ZERO = '0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        valid_in = 1'b0;
  logic [17:0] dividend = '0;

  logic [17:0] q3, q5, q7, q11;
  logic [1:0]  r3;
  logic [2:0]  r5, r7;
  logic [3:0]  r11;
  logic        v3, v5, v7, v11;

  int nchecks = 0;
  int nerrors = 0;

  logic [31:0] act_q [4];
  logic [31:0] act_r [4];
  logic        act_v [4];

  exp_t cur_exp  [4];
  exp_t last_exp [3];
  exp_t sbq [3][$];
  vec_t tab [10];

  always #5 clk = ~clk;

  smalldiv #(.DIVIDER_VALUE(3), .DIVIDEND_WIDTH(18), .THEORETICAL_LUT_WIDTH(6),
             .REGISTER_IN(1), .REGISTER_OUT(1)) u_d3 (
    .clock(clk), .reset(rst), .enable(enable),
`ifdef SMALLDIV_VALID_EN
    .valid_in(valid_in), .valid_out(v3),
`endif
    .dividend(dividend), .quotient(q3), .remainder(r3));

  smalldiv #(.DIVIDER_VALUE(5), .DIVIDEND_WIDTH(18), .THEORETICAL_LUT_WIDTH(6),
             .REGISTER_IN(0), .REGISTER_OUT(1)) u_d5 (
    .clock(clk), .reset(rst), .enable(enable),
`ifdef SMALLDIV_VALID_EN
    .valid_in(valid_in), .valid_out(v5),
`endif
    .dividend(dividend), .quotient(q5), .remainder(r5));

  smalldiv #(.DIVIDER_VALUE(7), .DIVIDEND_WIDTH(18), .THEORETICAL_LUT_WIDTH(6),
             .REGISTER_IN(1), .REGISTER_OUT(0)) u_d7 (
    .clock(clk), .reset(rst), .enable(enable),
`ifdef SMALLDIV_VALID_EN
    .valid_in(valid_in), .valid_out(v7),
`endif
    .dividend(dividend), .quotient(q7), .remainder(r7));

  smalldiv #(.DIVIDER_VALUE(11), .DIVIDEND_WIDTH(18), .THEORETICAL_LUT_WIDTH(6),
             .REGISTER_IN(0), .REGISTER_OUT(0)) u_d11 (
    .clock(clk), .reset(rst), .enable(enable),
`ifdef SMALLDIV_VALID_EN
    .valid_in(valid_in), .valid_out(v11),
`endif
    .dividend(dividend), .quotient(q11), .remainder(r11));

`ifndef SMALLDIV_VALID_EN
  assign v3 = 1'b0;
  assign v5 = 1'b0;
  assign v7 = 1'b0;
  assign v11 = 1'b0;
`endif

  always_comb begin
    act_q[0] = 32'(q3);  act_r[0] = 32'(r3);  act_v[0] = v3;
    act_q[1] = 32'(q5);  act_r[1] = 32'(r5);  act_v[1] = v5;
    act_q[2] = 32'(q7);  act_r[2] = 32'(r7);  act_v[2] = v7;
    act_q[3] = 32'(q11); act_r[3] = 32'(r11); act_v[3] = v11;
  end

  function automatic int dv(input int i);
    case (i)
      0: return 3;
      1: return 5;
      2: return 7;
      default: return 11;
    endcase
  endfunction

  function automatic int lat(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t tab_exp(input vec_t t, input int i);
    exp_t e;
    e = '0;
    case (i)
      0: begin e.q = t.q3;  e.r = t.r3;  end
      1: begin e.q = t.q5;  e.r = t.r5;  end
      2: begin e.q = t.q7;  e.r = t.r7;  end
      default: begin e.q = t.q11; e.r = t.r11; end
    endcase
    return e;
  endfunction

  task automatic check(input int i, input exp_t e, input string tag);
    nchecks++;
    if (act_q[i] != e.q || act_r[i] != e.r
`ifdef SMALLDIV_VALID_EN
        || act_v[i] != e.v
`endif
       ) begin
      nerrors++;
      $display("FAIL %s D=%0d got q=%0d r=%0d v=%0d expected q=%0d r=%0d v=%0d",
               tag, dv(i), act_q[i], act_r[i], act_v[i], e.q, e.r, e.v);
    end
  endtask

  // Drive one cycle of stimulus; tidx >= 0 takes hand-computed expectations from the table
  task automatic apply(input int unsigned x, input bit vin, input bit en, input int tidx);
    @(negedge clk);
    dividend = 18'(x);
    valid_in = vin;
    enable   = en;
    for (int i = 0; i < 4; i++) begin
      if (tidx >= 0) begin
        cur_exp[i] = tab_exp(tab[tidx], i);
      end else begin
        cur_exp[i]   = '0;
        cur_exp[i].q = 32'(x / 32'(dv(i)));
        cur_exp[i].r = 32'(x % 32'(dv(i)));
      end
      cur_exp[i].v = vin;
    end
    #1 check(3, cur_exp[3], (tidx >= 0) ? "tab_comb" : "comb");
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check(i, ZERO, "reset_async");
      sbq[i].delete();
    end
    repeat (cycles) @(negedge clk);
    for (int i = 0; i < 3; i++) check(i, ZERO, "reset_hold");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      last_exp[i] = ZERO;
      if (lat(i) == 2) sbq[i].push_back(ZERO);
    end
  endtask

  // Scoreboard for registered configurations: push on every enabled edge, pop once latency is covered
  always @(posedge clk) begin
    logic en_s, rst_s;
    exp_t e_s [4];
    en_s = enable;
    rst_s = rst;
    e_s = cur_exp;
    #1;
    if (!rst_s) begin
      for (int i = 0; i < 3; i++) begin
        if (en_s) begin
          sbq[i].push_back(e_s[i]);
          if (sbq[i].size() >= lat(i)) begin
            last_exp[i] = sbq[i].pop_front();
            check(i, last_exp[i], "pipe");
          end
        end else begin
          check(i, last_exp[i], "hold");
        end
      end
    end
  end

  initial begin
    tab[0] = '{32'd0,      32'd0,     32'd0, 32'd0,     32'd0, 32'd0,     32'd0, 32'd0,     32'd0};
    tab[1] = '{32'd1,      32'd0,     32'd1, 32'd0,     32'd1, 32'd0,     32'd1, 32'd0,     32'd1};
    tab[2] = '{32'd10,     32'd3,     32'd1, 32'd2,     32'd0, 32'd1,     32'd3, 32'd0,     32'd10};
    tab[3] = '{32'd11,     32'd3,     32'd2, 32'd2,     32'd1, 32'd1,     32'd4, 32'd1,     32'd0};
    tab[4] = '{32'd100,    32'd33,    32'd1, 32'd20,    32'd0, 32'd14,    32'd2, 32'd9,     32'd1};
    tab[5] = '{32'd12345,  32'd4115,  32'd0, 32'd2469,  32'd0, 32'd1763,  32'd4, 32'd1122,  32'd3};
    tab[6] = '{32'd65535,  32'd21845, 32'd0, 32'd13107, 32'd0, 32'd9362,  32'd1, 32'd5957,  32'd8};
    tab[7] = '{32'd131072, 32'd43690, 32'd2, 32'd26214, 32'd2, 32'd18724, 32'd4, 32'd11915, 32'd7};
    tab[8] = '{32'd262142, 32'd87380, 32'd2, 32'd52428, 32'd2, 32'd37448, 32'd6, 32'd23831, 32'd1};
    tab[9] = '{32'd262143, 32'd87381, 32'd0, 32'd52428, 32'd3, 32'd37449, 32'd0, 32'd23831, 32'd2};
    for (int i = 0; i < 4; i++) cur_exp[i] = ZERO;
    for (int i = 0; i < 3; i++) last_exp[i] = ZERO;

    do_reset(2);

    for (int t = 0; t < 10; t++) apply(tab[t].x, 1'(t % 2), 1'b1, t);

    // Incrementing sweep with a 3-cycle enable stall and a mid-stream reset
    for (int unsigned x = 0; x < 3000; x++) begin
      if (x == 1500) begin
        for (int k = 0; k < 3; k++) apply(777 + k, 1'b1, 1'b0, -1);
      end
      if (x == 2500) do_reset(2);
      apply(x, (x % 3) != 0, 1'b1, -1);
    end

    for (int unsigned x = 262143 - 999; x <= 262143; x++) apply(x, x[0], 1'b1, -1);

    for (int n = 0; n < 1500; n++)
      apply($urandom_range(262143, 0), 1'($urandom_range(1, 0)),
            $urandom_range(9, 0) != 0, -1);

    apply(0, 1'b0, 1'b1, -1);
    apply(0, 1'b0, 1'b1, -1);
    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/smalldiv.md
Name: smalldiv

Overview:
- Divides an unsigned dividend by a compile-time constant small divider; returns quotient and remainder.
- Combinational core: MSB-first chunked long division, one small LUT per chunk, each LUT sized for a target FPGA LUT input width.
- Optional input and output registers.
- Used wherever the datapath needs cheap division or modulo by 3, 5, 7, 11, …

Parameters:
- DIVIDER_VALUE, 5, constant divisor; integer >= 2.
- DIVIDEND_WIDTH, 18, dividend and quotient width in bits; >= 1.
- THEORETICAL_LUT_WIDTH, 6, target LUT input count per division step; must exceed RW (defined below).
- REGISTER_IN, 1, non-zero: register dividend on input.
- REGISTER_OUT, 1, non-zero: register quotient/remainder on output.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  clock enable for all internal registers.
- dividend  in  DIVIDEND_WIDTH  unsigned dividend.
- quotient  out  DIVIDEND_WIDTH  floor(dividend / DIVIDER_VALUE).
- remainder  out  RW  dividend mod DIVIDER_VALUE.

Behaviour:
- Derived widths:
  - RW = $clog2(DIVIDER_VALUE).
  - CW = THEORETICAL_LUT_WIDTH - RW (chunk width).
  - NS = ceil(DIVIDEND_WIDTH / CW) (number of stages).
- The dividend is zero-extended on the MSB side to NS*CW bits.
- Stage k (MSB chunk first):
  - Input: rem_in (RW bits; 0 for the first stage) concatenated with chunk k.
  - LUT output: qchunk = ({rem_in,chunk}) / D, CW bits; rem_out = ({rem_in,chunk}) % D.
  - Each LUT is a constant function elaborated at compile time.
- quotient = concatenated qchunks, truncated to DIVIDEND_WIDTH. remainder = rem_out of the last stage.
- Outputs are exact for every value in 0 .. 2^DIVIDEND_WIDTH-1.
- Latency = (REGISTER_IN!=0) + (REGISTER_OUT!=0) cycles, i.e. 0, 1 or 2.
  - With both registers off the path is purely combinational; clock, enable and reset are unused.
  - Fully pipelined: a new dividend is accepted every enabled cycle.
- Registers load only on a rising clock edge with enable=1. With enable=0 all registers hold, so the output stays aligned with the dividend presented latency-enabled-cycles earlier.
- Reset: every input and output register clears to 0 immediately. A registered output therefore reads quotient=0, remainder=0, which matches 0/D.
- Reset mid-stream discards all in-flight values. After release, outputs track new inputs after the usual latency.
- No internal remainder carry exists across pipeline registers. All stages sit between the input register and the output register.

Optional Feature:
- Macro SMALLDIV_VALID_EN.
- When defined, adds two ports:
  - valid_in (in, 1).
  - valid_out (out, 1): valid_in delayed through the same enable-gated registers. It is reset to 0 and equals valid_in combinationally when latency is 0.
- When undefined, these ports do not exist and there is no extra logic.

Decomposition:
- Package smalldiv_pkg holds constant functions for RW, CW and NS, plus a function lut_q/lut_r(value, divider) used to build the LUT contents.
- Sub-module smalldiv_stage (params DIVIDER_VALUE, RW, CW; ports rem_in, chunk, qchunk, rem_out) is one combinational step.
- smalldiv generates NS instances of smalldiv_stage and wraps the optional registers around them.

Test Plan:
- D=3, W=18, REG_IN=1, REG_OUT=1; incrementing dividend every enabled cycle from 0 to 2^18-1 -> 2 cycles later quotient=x/3, remainder=x%3. Spot check: 262143 -> q=87381, r=0.
- D=5, REG_IN=0, REG_OUT=1, exhaustive sweep -> 1-cycle latency. Spot check: 262142 -> q=52428, r=2.
- D=7, REG_IN=1, REG_OUT=0, exhaustive sweep -> 1-cycle latency. Spot check: 100 -> q=14, r=2.
- D=11, no registers, exhaustive sweep -> same-cycle result. Spot check: 262143 -> q=23831, r=2.
- Registered configuration:
  - Hold enable=0 for 3 cycles mid-sweep -> outputs frozen; the sequence resumes with no gap or duplicate.
  - Assert reset mid-sweep -> outputs 0 immediately; after release the first result reappears after the latency.
- SMALLDIV_VALID_EN defined with valid_in pulses -> valid_out follows with the configured latency and is 0 during reset.
